// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder with a stall handshake and configurable latency.
// Optional access statistics outputs are enabled with `define DMEM_STATS_EN.
module data_mem_responder #(
  parameter int Bits    = 64,
  parameter int MemSize = 32,
  parameter int Latency = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [Bits-1:0] mem_access_addr,
  input  logic [Bits-1:0] mem_write_data,
  input  logic            mem_write_en,
  input  logic            mem_read,
  output logic [Bits-1:0] mem_read_data,
  output logic            mem_stall,
  output logic            mem_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]     rd_count,
  output logic [31:0]     wr_count,
  output logic [31:0]     stall_cycles
`endif
);

  localparam int Off = $clog2(Bits / 8);
  localparam int Aw  = (MemSize > 1) ? $clog2(MemSize) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [Bits-1:0] mem [MemSize];
  logic [Bits-1:0] word_idx;
  logic [Bits-1:0] lat_wdata;
  logic [Bits-1:0] rd_q;
  logic [Aw-1:0]   lat_idx;
  logic            lat_wr, lat_rd, lat_conf, lat_oor;
  logic            req, accept, in_range, commit_wr, commit_rd;

  // Requests are masked during reset so the stall cannot rise while the FSM is held in IDLE.
  assign req       = (mem_read | mem_write_en) & ~rst;
  assign word_idx  = mem_access_addr >> Off;
  assign in_range  = word_idx < Bits'(MemSize);
  assign accept    = (state == IDLE) && req;
  assign commit_wr = (state == DONE) && lat_wr && !lat_oor;
  assign commit_rd = (state == DONE) && lat_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_stall = 1'b0;
    mem_err   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          mem_stall = 1'b1;
          cnt_nxt   = 4'(Latency - 1);
          state_nxt = (Latency == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (cnt <= 4'd1) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        mem_err   = lat_oor | lat_conf;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
      lat_rd    <= 1'b0;
      lat_conf  <= 1'b0;
      lat_oor   <= 1'b0;
    end else if (accept) begin
      lat_idx   <= word_idx[Aw-1:0];
      lat_wdata <= mem_write_data;
      lat_wr    <= mem_write_en;
      lat_rd    <= mem_read & ~mem_write_en;
      lat_conf  <= mem_read & mem_write_en;
      lat_oor   <= ~in_range;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MemSize; i++) mem[i] <= '0;
    end else if (commit_wr) begin
      mem[lat_idx] <= lat_wdata;
    end
  end

  // The completing load is visible combinationally; the register only provides the hold value.
  always_comb begin
    mem_read_data = rd_q;
    if (commit_rd) mem_read_data = lat_oor ? '0 : mem[lat_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else if (commit_rd) rd_q <= mem_read_data;
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count     <= '0;
      wr_count     <= '0;
      stall_cycles <= '0;
    end else begin
      if (commit_rd && !lat_oor && rd_count != '1) rd_count <= rd_count + 32'd1;
      if (commit_wr && wr_count != '1) wr_count <= wr_count + 32'd1;
      if (mem_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle responder for the pipeline's data-memory port. It services the MEM-stage load/store request (address, write data, write enable, read enable) with a configurable access latency.
- Drives a stall back to the pipeline while an access is in flight.
- Replaces the single-cycle data memory, so the core can be evaluated against realistic memory timing.

Parameters:
- Bits, 64, data word width in bits; must be a power of two, at least 8.
- MemSize, 32, number of Bits-wide words stored.
- Latency, 2, cycles from request acceptance to completion; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_access_addr  input  Bits  byte address from EX_MEM ALU result.
- mem_write_data  input  Bits  store data.
- mem_write_en  input  1  store request, level-held by the pipeline while stalled.
- mem_read  input  1  load request, level-held by the pipeline while stalled.
- mem_read_data  output  Bits  load result; valid in the completion cycle and held until the next load completes.
- mem_stall  output  1  high while a request is pending and not yet complete.
- mem_err  output  1  one-cycle pulse on an out-of-range or conflicting access.

Behaviour:
- Reset values: mem_read_data=0, mem_stall=0, mem_err=0, FSM=IDLE, counter=0, all MemSize words cleared to 0.
- Word index: mem_access_addr >> log2(Bits/8). Low byte-offset bits are ignored; the access is always a full word.
- An access is out of range when the word index is >= MemSize.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - If mem_read or mem_write_en is high: latch address, write data and operation; load counter with Latency-1.
  - mem_stall is high combinationally in this same cycle.
  - Next state is DONE if Latency==1, else BUSY.
- BUSY:
  - mem_stall=1 and the counter decrements each cycle.
  - When the counter reaches 1, next state is DONE.
- DONE (exactly one cycle):
  - mem_stall=0.
  - Store: the latched word is written at the clock edge ending this cycle.
  - Load: mem_read_data presents the latched word combinationally from the array, and is registered so it holds afterwards.
  - Next state is IDLE unconditionally. The request inputs seen during DONE belong to the instruction leaving MEM and are not re-accepted.
- IDLE with no request: mem_stall=0; mem_read_data holds its last value.
- mem_read and mem_write_en both high at acceptance:
  - The store wins and the load is not performed.
  - mem_err pulses in DONE.
  - mem_read_data is unchanged.
- Out-of-range access:
  - Full latency is still taken.
  - A store is dropped; a load returns 0.
  - mem_err pulses in DONE.
- Request inputs that change while in BUSY are ignored because the latched copies are used. The pipeline holds them stable in any case.
- Back-to-back requests: a new request is accepted in the IDLE cycle immediately after DONE. Minimum period is Latency+1 cycles per access.
- Reset asserted mid-access:
  - Immediate return to IDLE with mem_stall=0 and mem_err=0.
  - A pending store is discarded and the array is cleared.
- Load after store to the same word: returns the new value, because the store commits at the end of DONE and the next access completes no earlier than two cycles later.

Optional Feature:
- Macro: DMEM_STATS_EN.
- With the macro defined, three outputs are added:
  - rd_count (32-bit): increments in DONE of each in-range load.
  - wr_count (32-bit): increments in DONE of each in-range store.
  - stall_cycles (32-bit): increments every cycle mem_stall=1.
  - All three counters saturate at all-ones and reset to 0.
- Without the macro, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single store then load, Latency=2:
  - Stimulus: store 0x0123456789ABCDEF at addr 0x10, then load addr 0x10.
  - mem_stall is high for 2 cycles per access.
  - The load's DONE cycle shows mem_read_data=0x0123456789ABCDEF.
- Latency=1, 4-word sequence:
  - Stimulus: stores at addr 0x00, 0x08, 0x10 and 0x18, then loads in reverse order.
  - Each access stalls exactly 1 cycle; values return correctly; total time is 16 cycles.
- Out-of-range access, MemSize=32:
  - Load at addr 0x100 (word 32) returns 0 with mem_err=1 for one cycle.
  - Store at the same address leaves words 0..31 unchanged.
- Read/write conflict:
  - Stimulus: mem_read=1 and mem_write_en=1, write data 0xAA at addr 0x08.
  - Word 1 becomes 0xAA, mem_err pulses, mem_read_data is unchanged.
  - A subsequent load returns 0xAA.
- Reset mid-access:
  - Stimulus: assert rst in the second BUSY cycle of a store of 0x55 with Latency=3.
  - mem_stall drops asynchronously and the FSM is IDLE.
  - A load of that address after reset returns 0.
- DMEM_STATS_EN build:
  - Stimulus: 3 loads and 2 stores with Latency=2.
  - Required: rd_count=3, wr_count=2, stall_cycles=10.
